// File: rtl/uart_ebi_master_pkg.sv
// uart_ebi_pkg: definitions shared by both ends of the UART-to-EBI register link.
//   - Frame header bytes and the CRC seed.
//   - Reply status codes returned on rsp_status.
//   - Master FSM state encoding.
//   - crc8(): CRC-8, polynomial 0x07, MSB-first, one byte per call.
//     The responder uses the same function.
package uart_ebi_pkg;

    localparam logic [7:0] HDR_RD   = 8'hAA;
    localparam logic [7:0] HDR_WR   = 8'hAB;
    localparam logic [7:0] HDR_RSP  = 8'hAC;
    localparam logic [7:0] CRC_INIT = 8'h14;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_CRC_ERR = 2'd1,
        ST_NACK    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

    typedef enum logic [3:0] {
        S_IDLE, S_TX_HDR, S_TX_AH, S_TX_AL, S_TX_DH, S_TX_DL, S_TX_CRC,
        S_RX_HDR, S_RX_DH, S_RX_DL, S_RX_CRC, S_DONE
    } state_e;

    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_ebi_master_if.sv
// uart_ebi_master_if: local request/response bus of the UART-to-EBI master.
//   Request side:  req_valid, req_ready, req_write, req_addr[15:0], req_wdata[15:0].
//   Response side: rsp_valid (one-cycle pulse), rsp_rdata[15:0], rsp_status[1:0].
//   The host side uses the master modport; uart_ebi_master uses the slave modport.
interface uart_ebi_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_status;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_status
    );
endinterface

// File: rtl/uart_ebi_master_uart.sv
// uart: 8N1 UART core with AXI-stream style byte ports.
//   Bit period  = prescale * 8 clk cycles.
//   TX side:    s_axis_tdata / tvalid / tready, drives txd.
//   RX side:    m_axis_tdata / tvalid / tready, samples rxd.
//   Status:     tx_busy and rx_busy levels.
//               rx_overrun_error and rx_frame_error are one-cycle pulses.
//   A byte whose stop bit is low raises rx_frame_error and is not presented on m_axis.
module uart #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    input  logic [15:0]           prescale
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 2);

    logic [18:0] bit_period, half_period;
    assign bit_period  = {prescale, 3'b000} - 19'd1;
    assign half_period = {1'b0, prescale, 2'b00} - 19'd1;

    logic [18:0]         tx_tmr_q;
    logic [DATA_WIDTH:0] tx_sh_q;
    logic [CNT_W-1:0]    tx_cnt_q;
    logic                tx_busy_q, txd_q;

    assign s_axis_tready = !tx_busy_q;
    assign tx_busy       = tx_busy_q;
    assign txd           = txd_q;

    // Start bit goes out on accept; tx_cnt_q counts the data+stop bits still to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_tmr_q  <= '0;
            tx_sh_q   <= '0;
            tx_cnt_q  <= '0;
            tx_busy_q <= 1'b0;
            txd_q     <= 1'b1;
        end else if (!tx_busy_q) begin
            if (s_axis_tvalid) begin
                tx_busy_q <= 1'b1;
                txd_q     <= 1'b0;
                tx_sh_q   <= {1'b1, s_axis_tdata};
                tx_cnt_q  <= CNT_W'(DATA_WIDTH + 1);
                tx_tmr_q  <= bit_period;
            end
        end else if (tx_tmr_q != '0) begin
            tx_tmr_q <= tx_tmr_q - 19'd1;
        end else if (tx_cnt_q != '0) begin
            txd_q    <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
            tx_tmr_q <= bit_period;
        end else begin
            tx_busy_q <= 1'b0;
        end
    end

    logic [1:0]            rxd_sync_q;
    logic [18:0]           rx_tmr_q;
    logic [DATA_WIDTH-1:0] rx_sh_q, m_data_q;
    logic [CNT_W-1:0]      rx_cnt_q;
    logic                  rx_busy_q, m_valid_q, ovr_q, fe_q;

    assign m_axis_tdata     = m_data_q;
    assign m_axis_tvalid    = m_valid_q;
    assign rx_busy          = rx_busy_q;
    assign rx_overrun_error = ovr_q;
    assign rx_frame_error   = fe_q;

    // Half a bit after the falling edge the start bit is re-checked (glitch reject).
    // From then on every sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_sync_q <= 2'b11;
            rx_tmr_q   <= '0;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_busy_q  <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            rxd_sync_q <= {rxd_sync_q[0], rxd};
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            if (m_valid_q && m_axis_tready) m_valid_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rxd_sync_q[1]) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= CNT_W'(DATA_WIDTH + 1);
                    rx_tmr_q  <= half_period;
                end
            end else if (rx_tmr_q != '0) begin
                rx_tmr_q <= rx_tmr_q - 19'd1;
            end else if (rx_cnt_q == CNT_W'(DATA_WIDTH + 1)) begin
                if (rxd_sync_q[1]) begin
                    rx_busy_q <= 1'b0;
                end else begin
                    rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                    rx_tmr_q <= bit_period;
                end
            end else if (rx_cnt_q != '0) begin
                rx_sh_q  <= {rxd_sync_q[1], rx_sh_q[DATA_WIDTH-1:1]};
                rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                rx_tmr_q <= bit_period;
            end else begin
                rx_busy_q <= 1'b0;
                if (rxd_sync_q[1]) begin
                    m_data_q  <= rx_sh_q;
                    m_valid_q <= 1'b1;
                    ovr_q     <= m_valid_q && !m_axis_tready;
                end else begin
                    fe_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/uart_ebi_master.sv
// uart_ebi_master: host-side initiator for the UART-to-EBI register link.
//   Turns 16-bit read/write requests on bus (slave modport) into CRC-8 command frames.
//   For reads, parses the AC reply and returns data plus a status code.
//   Ports:
//     clk, rst_n  clock and async active-low reset
//     prescale    Fclk / (baud * 8)
//     bus         request/response interface
//     txd, rxd    serial pair
//     flags       UART busy/error passthrough
//   Build option: define UART_EBI_MASTER_TIMEOUT_EN to make read replies time out.
//   A reply times out TIMEOUT_CYCLES clk cycles after the last CRC accept or received byte.
//   Without the option a lost reply waits until reset.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | req_ready = 1, waiting for a request
//   TX_HDR   | sending AA (read) / AB (write)
//   TX_AH/AL | sending address high / low byte
//   TX_DH/DL | sending write data high / low byte (writes only)
//   TX_CRC   | sending request CRC
//   RX_HDR   | dropping bytes until AC arrives
//   RX_DH/DL | capturing reply data high / low byte
//   RX_CRC   | checking reply CRC, setting status
//   DONE     | one-cycle rsp_valid, then back to IDLE
module uart_ebi_master
    import uart_ebi_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100000000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       prescale,
    uart_ebi_master_if.slave  bus,
    output logic              txd,
    input  logic              rxd,
    output logic              tx_busy,
    output logic              rx_busy,
    output logic              rx_overrun_error,
    output logic              rx_frame_error
);
    if (CLK_FREQ_HZ < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("uart_ebi_master: CLK_FREQ_HZ must be positive and TIMEOUT_CYCLES at least 2");
    end

    state_e      state_q, state_d;
    status_e     status_q, status_d;
    logic        write_q, write_d, rsp_valid_q, rsp_valid_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rx_data_q, rx_data_d, rdata_q, rdata_d;
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  tx_data, rx_byte;
    logic        tx_valid, tx_ready, rx_valid, timeout;

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_status = status_q;

    uart #(.DATA_WIDTH(8)) uart_inst (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (tx_data),
        .s_axis_tvalid    (tx_valid),
        .s_axis_tready    (tx_ready),
        .m_axis_tdata     (rx_byte),
        .m_axis_tvalid    (rx_valid),
        .m_axis_tready    (1'b1),
        .rxd              (rxd),
        .txd              (txd),
        .tx_busy          (tx_busy),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
        .prescale         (prescale)
    );

`ifdef UART_EBI_MASTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    // Loaded one short of the full count and checked against zero.
    // The DONE cycle itself is then the TIMEOUT_CYCLES-th cycle after the last event.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 2);
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             rx_state;

    assign rx_state = (state_q == S_RX_HDR) || (state_q == S_RX_DH) ||
                      (state_q == S_RX_DL)  || (state_q == S_RX_CRC);
    assign timeout  = rx_state && !rx_valid && (tmr_q == '0);

    always_comb begin
        tmr_d = tmr_q;
        if (state_q == S_TX_CRC) tmr_d = TMR_LOAD;
        else if (rx_state)       tmr_d = rx_valid ? TMR_LOAD : tmr_q - TMR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmr_q <= TMR_LOAD;
        else        tmr_q <= tmr_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rx_data_d   = rx_data_q;
        rdata_d     = rdata_q;
        crc_d       = crc_q;
        rsp_valid_d = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                write_d = bus.req_write;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                crc_d   = CRC_INIT;
                state_d = S_TX_HDR;
            end
            S_TX_HDR, S_TX_AH, S_TX_AL, S_TX_DH, S_TX_DL: begin
                tx_valid = 1'b1;
                case (state_q)
                    S_TX_HDR: tx_data = write_q ? HDR_WR : HDR_RD;
                    S_TX_AH:  tx_data = addr_q[15:8];
                    S_TX_AL:  tx_data = addr_q[7:0];
                    S_TX_DH:  tx_data = wdata_q[15:8];
                    default:  tx_data = wdata_q[7:0];
                endcase
                if (tx_ready) begin
                    crc_d = crc8(crc_q, tx_data);
                    case (state_q)
                        S_TX_HDR: state_d = S_TX_AH;
                        S_TX_AH:  state_d = S_TX_AL;
                        S_TX_AL:  state_d = write_q ? S_TX_DH : S_TX_CRC;
                        S_TX_DH:  state_d = S_TX_DL;
                        default:  state_d = S_TX_CRC;
                    endcase
                end
            end
            S_TX_CRC: begin
                tx_valid = 1'b1;
                tx_data  = crc_q;
                if (tx_ready) begin
                    crc_d = CRC_INIT;
                    if (write_q) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rdata_d     = 16'h0000;
                        status_d    = ST_OK;
                    end else begin
                        state_d = S_RX_HDR;
                    end
                end
            end
            S_RX_HDR: if (rx_valid && rx_byte == HDR_RSP) begin
                crc_d   = crc8(crc_q, rx_byte);
                state_d = S_RX_DH;
            end
            S_RX_DH: if (rx_valid) begin
                crc_d            = crc8(crc_q, rx_byte);
                rx_data_d[15:8]  = rx_byte;
                state_d          = S_RX_DL;
            end
            S_RX_DL: if (rx_valid) begin
                crc_d           = crc8(crc_q, rx_byte);
                rx_data_d[7:0]  = rx_byte;
                state_d         = S_RX_CRC;
            end
            S_RX_CRC: if (rx_valid) begin
                rdata_d     = rx_data_q;
                rsp_valid_d = 1'b1;
                state_d     = S_DONE;
                // A CRC with only bit 0 flipped is the responder's NACK signal.
                if (rx_byte == crc_q)                  status_d = ST_OK;
                else if (rx_byte == (crc_q ^ 8'h01))   status_d = ST_NACK;
                else                                   status_d = ST_CRC_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rdata_d     = 16'h0000;
            status_d    = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            status_q    <= ST_OK;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rx_data_q   <= '0;
            rdata_q     <= '0;
            crc_q       <= CRC_INIT;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rx_data_q   <= rx_data_d;
            rdata_q     <= rdata_d;
            crc_q       <= crc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
endmodule
